matrix_inverse_seq: RTL and testbench
=====================================

# matrix_inverse_seq

- Sequential, parametrised N×N exact-integer matrix inverter using fraction-free (Bareiss) Gauss-Jordan elimination with row pivoting.
- Successor to the combinational 5×5 inverse. Matrix size is a parameter, elements stream in and out over valid/ready, and singular inputs are flagged.
- Output is an integer matrix M and a scale s with A·M = s·I, so A⁻¹ = M/s. Sits between the matrix loader and the linear-system solve stage.

## Interface

Parameters:
- N, default 5: matrix dimension, ≥2.
- DW, default 32: signed input element width.
- AW, default 64: signed internal/output width, > DW.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  input element valid.
- in_ready  out  1  high in IDLE/LOAD only.
- in_data  in  DW  signed element, row-major a[0][0]..a[N-1][N-1].
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts.
- out_data  out  AW  signed M element, row-major.
- out_scale  out  AW  s; valid whenever out_valid.
- out_singular  out  1  matrix singular; valid whenever out_valid.
- busy  out  1  high from first accepted input until last output beat accepted.

## Operation

- Storage: working array W of N rows × 2N columns, AW bits each, plus prev (AW) and a swap-parity bit.
- Load: each in_data is sign-extended into W[i][j]; W[i][N+j] is set to (i==j). prev is set to 1 and the parity bit is cleared.
- States: IDLE → LOAD → SEARCH → SWAP → ELIM → (next k: SEARCH | done: OUTPUT) → IDLE.
- SEARCH (column k):
  - Scans rows r = k..N-1, one per cycle, and stops at the first W[r][k]≠0.
  - If none is found: out_singular=1, go to OUTPUT.
- SWAP: if r≠k, rows r and k are exchanged in one cycle and the parity bit is toggled. If r==k the state is skipped (0 cycles).
- ELIM: for every row i≠k and column j∈[0,2N), j≠k, in ascending i then j:
  - W[i][j] ← (W[k][k]·W[i][j] − W[i][k]·W[k][j]) / prev.
  - The division is exact; a sequential signed restoring divider is used, with truncation toward zero.
  - After row i completes, W[i][k] ← 0. Column k is updated last so the old W[i][k] is used throughout the row.
  - After all rows: prev ← W[k][k]; k ← k+1.
- Done: s = W[N-1][N-1] = (−1)^swaps·det(A), and M = W[·][N..2N-1].
- OUTPUT: streams N² beats of M.
  - If singular: out_data=0 on every beat and out_scale=0.
- Arithmetic: products are formed at 2·AW and the quotient is truncated to AW. Overflow is not detected; the caller must size AW at or above the Hadamard bound.

## Timing

- Reset values: in_ready=0, out_valid=0, out_data=0, out_scale=0, out_singular=0, busy=0. State=IDLE.
- in_ready rises the first cycle after rst_n deasserts.
- Input: a beat transfers when in_valid&&in_ready. N² transfers are required. in_ready drops the cycle after the last transfer. Gaps in in_valid are allowed.
- Per element update: exactly AW+2 cycles (1 multiply, AW divide, 1 writeback).
- Per column k: (r−k+1) search cycles, +1 if swapped, + (N−1)(2N−1)(AW+2) elimination cycles.
- OUTPUT begins the cycle after the last ELIM writeback, or the cycle after a failed SEARCH.
- Output handshake:
  - A beat transfers when out_valid&&out_ready.
  - out_data, out_scale and out_singular hold stable while out_valid&&!out_ready.
  - After the N²-th transfer: out_valid=0, busy=0, return to IDLE. in_ready=1 the next cycle.
- rst_n asserted mid-load, mid-elimination or mid-output: immediate abort, all outputs return to reset values, partial data discarded.
- in_valid is ignored outside LOAD/IDLE. out_ready is ignored when out_valid=0.

## Test plan

- Identity: N=5, A=I → s=1, singular=0, M=I, 25 beats.
- Unit-determinant matrix: rows [1,1,1,1,1],[2,3,2,2,2],[3,3,4,3,3],[4,4,4,5,4],[5,5,5,5,6] → s=1.
  - M row0 = [15,−1,−1,−1,−1].
  - M row i (i=1..4): column 0 = −(i+1), column i = 1, all else 0.
- Pivoting: A = 5×5 anti-diagonal ones → exactly 2 swaps, s=+1, M=A.
  - Cycle count matches the latency formula.
- Singular: all-ones 5×5 → search fails at k=1, out_singular=1, out_scale=0, 25 beats of 0.
- Handshake: random in_valid gaps; out_ready toggling 50% on the unit-determinant case → outputs held stable during stalls, same values as the unstalled run.
  - Assert rst_n low mid-ELIM → all outputs return to reset values; a subsequent identity load completes correctly.

Source files
------------

// File: rtl/matrix_inverse_seq.sv
// matrix_inverse_seq: sequential N x N exact-integer inverse using fraction-free
// (Bareiss) Gauss-Jordan elimination with row pivoting. Produces M and s with
// A*M = s*I. Elements stream in and out row-major over valid/ready.
module matrix_inverse_seq #(
   parameter int N  = 5,
   parameter int DW = 32,
   parameter int AW = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_data,
   output logic [AW-1:0] out_scale,
   output logic          out_singular,
   output logic          busy
);
   localparam int RW  = $clog2(N);
   localparam int CW  = $clog2(2*N);
   localparam int DCW = $clog2(AW);
   localparam logic [RW-1:0]  RL  = RW'(N-1);
   localparam logic [RW-1:0]  RL2 = RW'(N-2);
   localparam logic [CW-1:0]  CL  = CW'(2*N-1);
   localparam logic [CW-1:0]  CN  = CW'(N);
   localparam logic [DCW-1:0] DL  = DCW'(AW-1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEARCH, S_SWAP, S_ELIM, S_OUT} state_t;
   typedef enum logic [1:0] {P_MUL, P_DIV, P_WB} phase_t;

   state_t state, state_n;
   phase_t ph;
   logic signed [AW-1:0] w [N][2*N];
   logic signed [AW-1:0] prev, scale;
   logic parity, sing, rdy, qneg;
   logic [RW-1:0] k, r, i, lr, lc, orow, ocol, ni;
   logic [CW-1:0] j, nj, kc;
   logic [DCW-1:0] dc;
   logic [2*AW-1:0] acc, acc_step, pabs;
   logic signed [AW-1:0] wkk, wij, wik, wkj;
   logic signed [2*AW-1:0] xkk, xij, xik, xkj, prod;
   logic [AW-1:0] dmag, rlow, qmag, qval;
   logic in_fire, out_fire, load_last, piv_nz, elim_done, ge;

   // Datapath helpers: cross-multiply, magnitudes, one restoring-divide step, index stepping
   always_comb begin
      kc        = CW'(k);
      wkk       = w[k][kc];
      wij       = w[i][j];
      wik       = w[i][kc];
      wkj       = w[k][j];
      xkk       = {{AW{wkk[AW-1]}}, wkk};
      xij       = {{AW{wij[AW-1]}}, wij};
      xik       = {{AW{wik[AW-1]}}, wik};
      xkj       = {{AW{wkj[AW-1]}}, wkj};
      prod      = xkk * xij - xik * xkj;
      pabs      = prod[2*AW-1] ? -prod : prod;
      dmag      = prev[AW-1] ? -prev : prev;
      // Remainder is always < divisor, so after the shift it needs AW+1 bits:
      // acc[2AW-1] is the extra bit and an AW-bit subtraction is exact.
      rlow      = acc[2*AW-2:AW-1];
      ge        = acc[2*AW-1] || (rlow >= dmag);
      acc_step  = ge ? {rlow - dmag, acc[AW-2:0], 1'b1} : {acc[2*AW-2:0], 1'b0};
      qmag      = acc[AW-1:0];
      qval      = qneg ? -qmag : qmag;
      ni        = i + RW'(1);
      if (ni == k) ni = i + RW'(2);
      nj        = j + CW'(1);
      if (nj == kc) nj = j + CW'(2);
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
      load_last = (lr == RL) && (lc == RL);
      piv_nz    = (w[r][kc] != '0);
      elim_done = (state == S_ELIM) && (ph == P_WB) && (j == CL) &&
                  (i == ((k == RL) ? RL2 : RL));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (in_fire) state_n = S_LOAD;
         S_LOAD:   if (in_fire && load_last) state_n = S_SEARCH;
         S_SEARCH: begin
            if (piv_nz)       state_n = (r != k) ? S_SWAP : S_ELIM;
            else if (r == RL) state_n = S_OUT;
         end
         S_SWAP:   state_n = S_ELIM;
         S_ELIM:   if (elim_done) state_n = (k == RL) ? S_OUT : S_SEARCH;
         S_OUT:    if (out_fire && (orow == RL) && (ocol == RL)) state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   // Control registers: counters, divider, pivot history, result flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy <= 1'b0; ph <= P_MUL; prev <= '0; scale <= '0; parity <= 1'b0;
         sing <= 1'b0; qneg <= 1'b0; k <= '0; r <= '0; i <= '0; j <= '0;
         lr <= '0; lc <= '0; orow <= '0; ocol <= '0; dc <= '0; acc <= '0;
      end else begin
         rdy <= (state_n == S_IDLE) || (state_n == S_LOAD);
         case (state)
            S_IDLE, S_LOAD: if (in_fire) begin
               if (state == S_IDLE) begin
                  prev <= AW'(1); parity <= 1'b0; sing <= 1'b0;
               end
               if (lc == RL) begin
                  lc <= '0;
                  if (lr == RL) begin lr <= '0; k <= '0; r <= '0; end
                  else lr <= lr + RW'(1);
               end else lc <= lc + RW'(1);
            end
            S_SEARCH: begin
               if (piv_nz) begin
                  i  <= (k == '0) ? RW'(1) : '0;
                  j  <= (k == '0) ? CW'(1) : '0;
                  ph <= P_MUL;
               end else if (r == RL) begin
                  sing <= 1'b1; scale <= '0;
               end else r <= r + RW'(1);
            end
            S_SWAP: parity <= ~parity;
            S_ELIM: case (ph)
               P_MUL: begin
                  acc <= pabs; qneg <= prod[2*AW-1] ^ prev[AW-1];
                  dc  <= '0;   ph   <= P_DIV;
               end
               P_DIV: begin
                  acc <= acc_step;
                  if (dc == DL) ph <= P_WB;
                  else          dc <= dc + DCW'(1);
               end
               default: begin
                  ph <= P_MUL;
                  if (j == CL) begin j <= (k == '0) ? CW'(1) : '0; i <= ni; end
                  else j <= nj;
                  if (elim_done) begin
                     prev <= wkk;
                     if (k == RL) scale <= wkk;
                     else begin k <= k + RW'(1); r <= k + RW'(1); end
                  end
               end
            endcase
            S_OUT: if (out_fire) begin
               if (ocol == RL) begin
                  ocol <= '0;
                  orow <= (orow == RL) ? '0 : orow + RW'(1);
               end else ocol <= ocol + RW'(1);
            end
            default: ;
         endcase
      end
   end

   // Working array: load, row swap, element writeback; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (in_fire) begin
         w[lr][CW'(lc)]      <= {{(AW-DW){in_data[DW-1]}}, in_data};
         w[lr][CN + CW'(lc)] <= (lr == lc) ? AW'(1) : '0;
      end else if (state == S_SWAP) begin
         for (int c = 0; c < 2*N; c++) begin
            w[k][CW'(c)] <= w[r][CW'(c)];
            w[r][CW'(c)] <= w[k][CW'(c)];
         end
      end else if ((state == S_ELIM) && (ph == P_WB)) begin
         w[i][j] <= qval;
         if (j == CL) w[i][kc] <= '0;
      end
   end

   assign in_ready     = rdy;
   assign out_valid    = (state == S_OUT);
   assign busy         = (state != S_IDLE);
   assign out_data     = (out_valid && !sing) ? w[orow][CN + CW'(ocol)] : '0;
   assign out_scale    = out_valid ? scale : '0;
   assign out_singular = out_valid && sing;
endmodule

// File: tb/tb_matrix_inverse_seq.sv
// Scoreboard bench for matrix_inverse_seq: stimulus pushes expected beats,
// the monitor pops and compares on every accepted output beat.
module tb_matrix_inverse_seq;
   localparam int N  = 5;
   localparam int DW = 16;
   localparam int AW = 32;
   localparam int ELIM_COL = (N-1) * (2*N-1) * (AW+2);
   localparam int LAT_ID   = 5 + N * ELIM_COL;
   localparam int LAT_PIV  = (5 + 3 + 1 + 1 + 1) + 2 + N * ELIM_COL;
   localparam int LAT_SING = 1 + ELIM_COL + 4;

   typedef struct packed {
      logic [AW-1:0] d;
      logic [AW-1:0] s;
      logic          g;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic in_ready, out_valid, out_singular, busy;
   logic [AW-1:0] out_data, out_scale;

   exp_t sbq[$];
   int nvec = 0, nerr = 0, cyc = 0, t_in = 0, t_out = 0;
   int a_mat[N*N], e_mat[N*N], e_scale;
   bit e_sing, stall_mode = 0;
   logic [AW-1:0] hd, hs;
   logic hg, held = 1'b0, ov_prev = 1'b0;

   matrix_inverse_seq #(.N(N), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_scale(out_scale), .out_singular(out_singular),
      .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   // Downstream ready: always 1, or a coin flip per cycle during the stall run
   initial forever begin
      @(posedge clk); #2;
      out_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // Monitor: hold-stability during stalls, latency stamp, scoreboard compare
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         held = 1'b0; ov_prev = 1'b0;
      end else begin
         if (held) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_data", $signed(out_data), $signed(hd));
            chk("hold_scale", $signed(out_scale), $signed(hs));
            chk("hold_singular", longint'(out_singular), longint'(hg));
         end
         if (out_valid && !ov_prev) t_out = cyc;
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL extra_beat: got data %0d, required no beat", $signed(out_data));
            end else begin
               e = sbq.pop_front();
               chk("data", $signed(out_data), $signed(e.d));
               chk("scale", $signed(out_scale), $signed(e.s));
               chk("singular", longint'(out_singular), longint'(e.g));
            end
         end
         held = out_valid && !out_ready;
         hd = out_data; hs = out_scale; hg = out_singular; ov_prev = out_valid;
      end
   end

   task automatic set_identity();
      for (int b = 0; b < N*N; b++) begin
         a_mat[b] = (b / N == b % N) ? 1 : 0;
         e_mat[b] = a_mat[b];
      end
      e_scale = 1; e_sing = 0;
   endtask

   task automatic set_unitdet();
      for (int b = 0; b < N*N; b++) begin
         int rr = b / N, cc = b % N;
         a_mat[b] = rr + 1 + ((rr == cc && rr > 0) ? 1 : 0);
         if (rr == 0) e_mat[b] = (cc == 0) ? 15 : -1;
         else         e_mat[b] = (cc == 0) ? -(rr + 1) : ((cc == rr) ? 1 : 0);
      end
      e_scale = 1; e_sing = 0;
   endtask

   task automatic set_anti();
      for (int b = 0; b < N*N; b++) begin
         a_mat[b] = (b % N == N - 1 - b / N) ? 1 : 0;
         e_mat[b] = a_mat[b];
      end
      e_scale = 1; e_sing = 0;
   endtask

   task automatic set_ones();
      for (int b = 0; b < N*N; b++) begin a_mat[b] = 1; e_mat[b] = 0; end
      e_scale = 0; e_sing = 1;
   endtask

   task automatic push_exp();
      exp_t e;
      for (int b = 0; b < N*N; b++) begin
         e.d = e_mat[b]; e.s = e_scale; e.g = e_sing;
         sbq.push_back(e);
      end
   endtask

   task automatic send_mat(input bit gaps);
      int idx = 0, guard = 0;
      while (idx < N*N && guard < 2000) begin
         @(negedge clk); guard++;
         if (gaps && $urandom_range(0, 2) == 0) in_valid = 1'b0;
         else begin in_valid = 1'b1; in_data = a_mat[idx][DW-1:0]; end
         if (in_valid && in_ready) begin
            idx++;
            if (idx == N*N) t_in = cyc + 1;
         end
      end
      @(negedge clk); in_valid = 1'b0;
      if (idx != N*N) chk("load_timeout", idx, N*N);
   endtask

   task automatic wait_done(input string nm);
      int guard = 0;
      while ((busy || sbq.size() != 0) && guard < 20000) begin
         @(negedge clk); guard++;
      end
      if (guard >= 20000) chk(nm, sbq.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_out_scale", longint'(out_scale), 0);
      chk("rst_out_singular", longint'(out_singular), 0);
      chk("rst_busy", longint'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", longint'(in_ready), 1);

      set_identity(); push_exp(); send_mat(0); wait_done("identity_timeout");
      chk("lat_identity", t_out - t_in, LAT_ID);
      chk("in_ready_idle", longint'(in_ready), 1);

      set_unitdet(); push_exp(); send_mat(0); wait_done("unitdet_timeout");

      set_anti(); push_exp(); send_mat(0); wait_done("pivot_timeout");
      chk("lat_pivot", t_out - t_in, LAT_PIV);

      set_ones(); push_exp(); send_mat(0); wait_done("singular_timeout");
      chk("lat_singular", t_out - t_in, LAT_SING);

      stall_mode = 1;
      set_unitdet(); push_exp(); send_mat(1); wait_done("stall_timeout");
      stall_mode = 0;

      // Abort mid-elimination: nothing is expected from the aborted matrix
      set_unitdet(); send_mat(0);
      repeat (300) @(negedge clk);
      chk("busy_mid_elim", longint'(busy), 1);
      rst_n = 1'b0; #1;
      chk("abort_in_ready", longint'(in_ready), 0);
      chk("abort_out_valid", longint'(out_valid), 0);
      chk("abort_out_data", longint'(out_data), 0);
      chk("abort_out_scale", longint'(out_scale), 0);
      chk("abort_out_singular", longint'(out_singular), 0);
      chk("abort_busy", longint'(busy), 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("abort_in_ready_back", longint'(in_ready), 1);

      set_identity(); push_exp(); send_mat(0); wait_done("post_abort_timeout");
      chk("lat_post_abort", t_out - t_in, LAT_ID);
      chk("queue_drained", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
